dcache_controller: RTL

//  Direct-mapped, write-back, write-allocate data cache and its controller FSM, placed between
//  the CPU's load/store path and the multi-cycle data memory.

---
 rtl/dcache_controller_pkg.sv | 28 ++
 rtl/dcache_controller_if.sv | 35 +++
 rtl/dcache_controller_store.sv | 65 ++++++
 rtl/dcache_controller.sv | 90 +++++++++
 4 files changed

// File: rtl/dcache_controller_pkg.sv
// ============================================================================
// Module   : dcache_controller_pkg
// Brief    : Shared state encodings, block geometry and byte-select helper
//            for the direct-mapped data cache.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dcache_controller_pkg;

    localparam int ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE      = 2'd0;
    localparam logic [ST_W-1:0] ST_WRITEBACK = 2'd1;
    localparam logic [ST_W-1:0] ST_FETCH     = 2'd2;
    localparam logic [ST_W-1:0] ST_UPDATE    = 2'd3;

    localparam int OFFSET_W = 2;
    localparam int BYTE_W   = 8;
    localparam int BLOCK_W  = 32;

    function automatic logic [BYTE_W-1:0] block_byte(input logic [BLOCK_W-1:0] blk,
                                                     input logic [OFFSET_W-1:0] off);
        return blk[{off, 3'b000} +: BYTE_W];
    endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_controller_if.sv
// ============================================================================
// Module   : dcache_controller_if
// Brief    : CPU load/store port and block-memory port of the data cache.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dcache_controller_if #(
    parameter int ADDR_W = 8
);
    logic              READ;
    logic              WRITE;
    logic [ADDR_W-1:0] ADDRESS;
    logic [7:0]        WRITEDATA;
    logic [7:0]        READDATA;
    logic              BUSYWAIT;
    logic              MEM_READ;
    logic              MEM_WRITE;
    logic [ADDR_W-3:0] MEM_ADDRESS;
    logic [31:0]       MEM_WRITEDATA;
    logic [31:0]       MEM_READDATA;
    logic              MEM_BUSYWAIT;

    modport slave (
        input  READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        output READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );

    modport master (
        output READ, WRITE, ADDRESS, WRITEDATA, MEM_READDATA, MEM_BUSYWAIT,
        input  READDATA, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );
endinterface

`default_nettype wire

// File: rtl/dcache_controller_store.sv
// ============================================================================
// Module   : dcache_controller_store
// Brief    : Data/tag/valid/dirty arrays with a byte-write port and a
//            block-fill port; valid and dirty clear on reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_controller_store
    import dcache_controller_pkg::*;
#(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 3
) (
    input  wire logic                i_clk,
    input  wire logic                i_rst,
    input  wire logic [INDEX_W-1:0]  i_idx,
    input  wire logic                i_byte_we,
    input  wire logic [OFFSET_W-1:0] i_byte_off,
    input  wire logic [BYTE_W-1:0]   i_byte_data,
    input  wire logic                i_fill_we,
    input  wire logic [TAG_W-1:0]    i_fill_tag,
    input  wire logic [BLOCK_W-1:0]  i_fill_data,
    output logic      [BLOCK_W-1:0]  o_blk_data,
    output logic      [TAG_W-1:0]    o_blk_tag,
    output logic                     o_blk_valid,
    output logic                     o_blk_dirty
);
    localparam int DEPTH = 1 << INDEX_W;

    logic [BLOCK_W-1:0] r_data  [DEPTH];
    logic [TAG_W-1:0]   r_tag   [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [DEPTH-1:0]   r_dirty;

    // Payload arrays carry no reset; only the status bits decide whether they are used.
    always_ff @(posedge i_clk) begin
        if (i_fill_we) begin
            r_data[i_idx] <= i_fill_data;
            r_tag[i_idx]  <= i_fill_tag;
        end else if (i_byte_we) begin
            r_data[i_idx][{i_byte_off, 3'b000} +: BYTE_W] <= i_byte_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill_we) begin
            r_valid[i_idx] <= 1'b1;
            r_dirty[i_idx] <= 1'b0;
        end else if (i_byte_we) begin
            r_dirty[i_idx] <= 1'b1;
        end
    end

    assign o_blk_data  = r_data[i_idx];
    assign o_blk_tag   = r_tag[i_idx];
    assign o_blk_valid = r_valid[i_idx];
    assign o_blk_dirty = r_dirty[i_idx];

endmodule

`default_nettype wire

// File: rtl/dcache_controller.sv
// ============================================================================
// Module   : dcache_controller
// Brief    : Direct-mapped write-back/write-allocate data cache controller:
//            hit compare, miss FSM (writeback/fetch/update), output decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_controller
    import dcache_controller_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int INDEX_W = 3
) (
    input  wire logic           CLK,
    input  wire logic           RESET,
    dcache_controller_if.slave  bus
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;

    logic [ST_W-1:0]     r_state;
    logic [ST_W-1:0]     w_next;
    logic [TAG_W-1:0]    w_tag;
    logic [INDEX_W-1:0]  w_idx;
    logic [OFFSET_W-1:0] w_off;
    logic [BLOCK_W-1:0]  w_blk;
    logic [TAG_W-1:0]    w_blk_tag;
    logic                w_valid;
    logic                w_dirty;
    logic                w_hit;
    logic                w_miss;
    logic                w_byte_we;
    logic                w_fill_we;

    assign w_tag  = bus.ADDRESS[ADDR_W-1 -: TAG_W];
    assign w_idx  = bus.ADDRESS[OFFSET_W +: INDEX_W];
    assign w_off  = bus.ADDRESS[OFFSET_W-1:0];
    assign w_hit  = w_valid && (w_blk_tag == w_tag);
    assign w_miss = (r_state == ST_IDLE) && (bus.READ || bus.WRITE) && !w_hit;

    // A write (including READ&WRITE) commits only as an IDLE hit, so a miss re-resolves after refill.
    assign w_byte_we = (r_state == ST_IDLE) && bus.WRITE && w_hit;
    assign w_fill_we = (r_state == ST_UPDATE);

    dcache_controller_store #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_store (
        .i_clk       (CLK),
        .i_rst       (RESET),
        .i_idx       (w_idx),
        .i_byte_we   (w_byte_we),
        .i_byte_off  (w_off),
        .i_byte_data (bus.WRITEDATA),
        .i_fill_we   (w_fill_we),
        .i_fill_tag  (w_tag),
        .i_fill_data (bus.MEM_READDATA),
        .o_blk_data  (w_blk),
        .o_blk_tag   (w_blk_tag),
        .o_blk_valid (w_valid),
        .o_blk_dirty (w_dirty)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (w_miss) w_next = w_dirty ? ST_WRITEBACK : ST_FETCH;
            ST_WRITEBACK: if (!bus.MEM_BUSYWAIT) w_next = ST_FETCH;
            ST_FETCH:     if (!bus.MEM_BUSYWAIT) w_next = ST_UPDATE;
            ST_UPDATE:    w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    assign bus.BUSYWAIT      = (r_state != ST_IDLE) || w_miss;
    assign bus.MEM_READ      = (r_state == ST_FETCH);
    assign bus.MEM_WRITE     = (r_state == ST_WRITEBACK);
    assign bus.MEM_ADDRESS   = (r_state == ST_WRITEBACK) ? {w_blk_tag, w_idx} : {w_tag, w_idx};
    assign bus.MEM_WRITEDATA = w_blk;
    assign bus.READDATA      = ((r_state == ST_IDLE) && bus.READ && !bus.WRITE && w_hit)
                             ? block_byte(w_blk, w_off) : 8'h00;

endmodule

`default_nettype wire
